// File: rtl/fsk_pkg.sv
// fsk_pkg: shared FSM state encoding and preamble constants
// for the FSK packet modulator.
package fsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    PRE  = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam int PRE_LEN = 8;
  localparam logic [PRE_LEN-1:0] PREAMBLE_PATTERN = 8'b10101010;

endpackage

// File: rtl/fsk_phase_acc.sv
// fsk_phase_acc: phase accumulator stepping by mark/space increment.
// Ports: clk, rst (sync high), clr, en, mark (bit select), msb (phase MSB).
module fsk_phase_acc #(
  parameter int PHASE_W   = 8,
  parameter int INC_SPACE = 4,
  parameter int INC_MARK  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic mark,
  output logic msb
);

  localparam logic [PHASE_W-1:0] INC_S = PHASE_W'(INC_SPACE);
  localparam logic [PHASE_W-1:0] INC_M = PHASE_W'(INC_MARK);

  logic [PHASE_W-1:0] phase;

  // wrap modulo 2^PHASE_W is the natural overflow of the adder
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + (mark ? INC_M : INC_S);
    end
  end

  assign msb = phase[PHASE_W-1];

endmodule

// File: rtl/fsk_packet_modulator.sv
// fsk_packet_modulator: serialises a PKT_W-bit word MSB-first, one bit per
// SAMP period, as a binary-FSK square wave. Macro FSK_PREAMBLE_EN adds an
// 8-symbol 10101010 preamble. Ports: CLOCK, RESET (sync, high), SAMP, SHIFT,
// DATA_IN/DATA_VALID/DATA_READY, TX_BIT, TX_ACTIVE, FSK_OUT, DONE.
module fsk_packet_modulator
  import fsk_pkg::*;
#(
  parameter int PKT_W     = 32,
  parameter int PHASE_W   = 8,
  parameter int INC_SPACE = 4,
  parameter int INC_MARK  = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             SAMP,
  input  logic             SHIFT,
  input  logic [PKT_W-1:0] DATA_IN,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  output logic             TX_BIT,
  output logic             TX_ACTIVE,
  output logic             FSK_OUT,
  output logic             DONE
);

  localparam int CNT_W = $clog2(PKT_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_W);

  state_t           state, state_d;
  logic [PKT_W-1:0] shreg, shreg_d;
  logic [CNT_W-1:0] bitcnt, bitcnt_d;
  logic             tx_bit, tx_bit_d;
  logic             active, active_d;
  logic             done, done_d;
  logic             ready, ready_d;
  logic             capture;
  logic             phase_msb;
`ifdef FSK_PREAMBLE_EN
  localparam int PC_W = $clog2(PRE_LEN);
  logic [PC_W-1:0]    pre_cnt, pre_cnt_d;
  logic [PRE_LEN-1:0] pre_sh, pre_sh_d;
`endif

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bitcnt_d = bitcnt;
    tx_bit_d = tx_bit;
    active_d = active;
    done_d   = 1'b0;
    capture  = 1'b0;
`ifdef FSK_PREAMBLE_EN
    pre_cnt_d = pre_cnt;
    pre_sh_d  = pre_sh;
`endif
    unique case (state)
      IDLE: begin
        if (DATA_VALID && ready) begin
          capture = 1'b1;
          shreg_d = DATA_IN;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (SAMP) begin
          active_d = 1'b1;
`ifdef FSK_PREAMBLE_EN
          tx_bit_d  = PREAMBLE_PATTERN[PRE_LEN-1];
          pre_sh_d  = PREAMBLE_PATTERN << 1;
          pre_cnt_d = '0;
          state_d   = PRE;
`else
          tx_bit_d = shreg[PKT_W-1];
          shreg_d  = shreg << 1;
          bitcnt_d = CNT_W'(1);
          state_d  = SEND;
`endif
        end
      end
`ifdef FSK_PREAMBLE_EN
      PRE: begin
        if (SAMP) begin
          if (pre_cnt == PC_W'(PRE_LEN - 1)) begin
            tx_bit_d = shreg[PKT_W-1];
            shreg_d  = shreg << 1;
            bitcnt_d = CNT_W'(1);
            state_d  = SEND;
          end else begin
            tx_bit_d  = pre_sh[PRE_LEN-1];
            pre_sh_d  = pre_sh << 1;
            pre_cnt_d = pre_cnt + PC_W'(1);
          end
        end
      end
`endif
      SEND: begin
        if (SAMP) begin
          if (bitcnt == LAST) begin
            active_d = 1'b0;
            tx_bit_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            tx_bit_d = shreg[PKT_W-1];
            shreg_d  = shreg << 1;
            bitcnt_d = bitcnt + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      tx_bit <= 1'b0;
      active <= 1'b0;
      done   <= 1'b0;
      ready  <= 1'b0;
`ifdef FSK_PREAMBLE_EN
      pre_cnt <= '0;
      pre_sh  <= '0;
`endif
    end else begin
      state  <= state_d;
      shreg  <= shreg_d;
      bitcnt <= bitcnt_d;
      tx_bit <= tx_bit_d;
      active <= active_d;
      done   <= done_d;
      ready  <= ready_d;
`ifdef FSK_PREAMBLE_EN
      pre_cnt <= pre_cnt_d;
      pre_sh  <= pre_sh_d;
`endif
    end
  end

  // SAMP wins over SHIFT: no phase step on a symbol boundary
  fsk_phase_acc #(
    .PHASE_W  (PHASE_W),
    .INC_SPACE(INC_SPACE),
    .INC_MARK (INC_MARK)
  ) u_phase (
    .clk (CLOCK),
    .rst (RESET),
    .clr (capture),
    .en  (active && SHIFT && !SAMP),
    .mark(tx_bit),
    .msb (phase_msb)
  );

  assign DATA_READY = ready;
  assign TX_BIT     = tx_bit;
  assign TX_ACTIVE  = active;
  assign FSK_OUT    = active && phase_msb;
  assign DONE       = done;

endmodule
